// File: rtl/mseq_pkg.sv
// Shared types and default sizing for the Mealy sequence run controller.
// Holds the controller state enum and the default parameter values.
// No logic; imported by the interface, matcher and top.
package mseq_pkg;

  localparam int DEF_MAX_LEN     = 8;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_TIMEOUT_CYC = 255;
  localparam int LEN_W           = $clog2(DEF_MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mealy_seq_ctrl_if.sv
// Config, control, serial-bit and status bundle of the sequence run controller.
// Pure wiring, no latency.
// No backpressure; in_valid qualifies each serial bit.
interface mealy_seq_ctrl_if
  import mseq_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W
) ();

  localparam int CFG_LEN_W = $clog2(MAX_LEN + 1);

  logic                 cfg_we;
  logic [MAX_LEN-1:0]   cfg_pattern;
  logic [CFG_LEN_W-1:0] cfg_len;
  logic                 cfg_overlap;
  logic [CNT_W-1:0]     cfg_target;
  logic                 start;
  logic                 abort;
  logic                 in_valid;
  logic                 in;
  logic                 busy;
  logic                 match;
  logic                 done;
  logic                 err;
  logic                 timeout;
  logic [CNT_W-1:0]     match_count;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    output start, abort, in_valid, in,
    input  busy, match, done, err, timeout, match_count
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    input  start, abort, in_valid, in,
    output busy, match, done, err, timeout, match_count
  );

endinterface

// File: rtl/mseq_matcher.sv
// Programmable Mealy bit-pattern matcher: history shift register, fill count, compare.
// Zero latency: match is combinational with the final bit of the pattern.
// No backpressure; only shift beats advance the history.
module mseq_matcher
  import mseq_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               clear,
  input  logic                               shift,
  input  logic                               overlap,
  input  logic                               din,
  input  logic [MAX_LEN-1:0]                 pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]       len,
  output logic                               match
);

  localparam int LW = $clog2(MAX_LEN + 1);

  logic [MAX_LEN-2:0] hist;
  logic [LW-1:0]      fill;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN:0]   len_bit;

  // Window of the newest len bits (incoming bit included) compared against the pattern
  always_comb begin
    window  = {hist, din};
    len_bit = (MAX_LEN+1)'(1) << len;
    mask    = MAX_LEN'(len_bit - 1'b1);
    match   = shift
            && (({1'b0, fill} + (LW+1)'(1)) >= {1'b0, len})
            && ((window & mask) == (pattern & mask));
  end

  // History and fill; a non-overlapping match forgets everything seen so far
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= window[MAX_LEN-2:0];
      if (match && !overlap)
        fill <= '0;
      else if (fill != LW'(MAX_LEN))
        fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/mealy_seq_ctrl.sv
// Run controller around mseq_matcher: config latch, IDLE/RUN/DONE FSM, match counter.
// match is same-cycle; done/err/timeout pulse one cycle after the deciding edge.
// No backpressure; MSEQ_TIMEOUT_EN adds an idle-cycle timeout that ends a run.
module mealy_seq_ctrl
  import mseq_pkg::*;
#(
  parameter int MAX_LEN     = DEF_MAX_LEN,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             reset,
  mealy_seq_ctrl_if.slave  bus
);

  localparam int LW = $clog2(MAX_LEN + 1);

  state_t             state, state_nx;
  logic [MAX_LEN-1:0] pat_q;
  logic [LW-1:0]      len_q;
  logic               ov_q;
  logic [CNT_W-1:0]   tgt_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_inc;
  logic               err_q;
  logic               cfg_take;
  logic [LW-1:0]      len_eff;
  logic               len_ok;
  logic               running;
  logic               hit;
  logic               target_hit;
  logic               start_ok;
  logic               start_bad;
  logic               to_expire;

  // Same-cycle cfg_we and start: start sees the freshly written length
  assign cfg_take   = (state == IDLE) && bus.cfg_we;
  assign len_eff    = cfg_take ? bus.cfg_len : len_q;
  assign len_ok     = (len_eff != '0) && (len_eff <= LW'(MAX_LEN));
  assign running    = (state == RUN);
  assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign target_hit = hit && (tgt_q != '0) && (cnt_inc == tgt_q);

  mseq_matcher #(.MAX_LEN(MAX_LEN)) u_matcher (
    .clk     (clk),
    .reset   (reset),
    .clear   (!running),
    .shift   (running && bus.in_valid),
    .overlap (ov_q),
    .din     (bus.in),
    .pattern (pat_q),
    .len     (len_q),
    .match   (hit)
  );

`ifdef MSEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;
  logic [TW-1:0] to_nx;
  logic          to_q;

  assign to_nx     = to_cnt + 1'b1;
  assign to_expire = running && !hit && (to_nx == TW'(TIMEOUT_CYC));

  // Idle-cycle counter: restarts on RUN entry and on every match
  always_ff @(posedge clk) begin
    if (!reset || !running || hit)
      to_cnt <= '0;
    else
      to_cnt <= to_nx;
  end

  // Timeout flag rides along with the DONE state it caused; abort suppresses it
  always_ff @(posedge clk) begin
    if (!reset)
      to_q <= 1'b0;
    else
      to_q <= to_expire && !bus.abort;
  end

  assign bus.timeout = to_q;
`else
  assign to_expire   = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // Next state; abort beats both target completion and timeout
  always_comb begin
    state_nx  = state;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          start_ok  = len_ok;
          start_bad = !len_ok;
          if (len_ok)
            state_nx = RUN;
        end
      end
      RUN: begin
        if (bus.abort)
          state_nx = IDLE;
        else if (target_hit || to_expire)
          state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, config registers, match counter and error pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      pat_q <= '0;
      len_q <= '0;
      ov_q  <= 1'b0;
      tgt_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= start_bad;
      if (cfg_take) begin
        pat_q <= bus.cfg_pattern;
        len_q <= bus.cfg_len;
        ov_q  <= bus.cfg_overlap;
        tgt_q <= bus.cfg_target;
      end
      if (start_ok)
        cnt_q <= '0;
      else if (hit)
        cnt_q <= cnt_inc;
    end
  end

  assign bus.busy        = running;
  assign bus.match       = hit;
  assign bus.done        = (state == DONE);
  assign bus.err         = err_q;
  assign bus.match_count = cnt_q;

endmodule

// File: doc/mealy_seq_ctrl.md
Name: mealy_seq_ctrl

Overview:
- Run-control wrapper around a programmable Mealy bit-sequence matcher.
- Software/upstream logic loads a pattern (1..MAX_LEN bits), a mode and a match target, then starts a run.
- The block streams qualified serial bits through the matcher, flags each match in the same cycle, counts matches, and terminates the run on target count or abort.
- It sits between the serial input front-end and the status/interrupt logic.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (2..16).
- CNT_W, 8: width of the match counter and target.
- TIMEOUT_CYC, 255: idle-cycle limit used only when MSEQ_TIMEOUT_EN is defined.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
- cfg_we  in  1  latch cfg_* into the config registers; honoured only in IDLE.
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the first bit expected on the line.
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length; legal range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_target  in  CNT_W  matches needed to finish; 0 = free-run until abort.
- start  in  1  one-cycle pulse; begins a run from IDLE.
- abort  in  1  ends a run immediately.
- in_valid  in  1  qualifies `in`.
- in  in  1  serial data bit.
- busy  out  1  high in RUN.
- match  out  1  Mealy match flag, combinational from `in`/`in_valid` and state.
- done  out  1  one-cycle pulse on normal or timeout completion.
- err  out  1  one-cycle pulse on a start with an illegal latched length.
- timeout  out  1  one-cycle pulse, coincident with done, on timeout.
- match_count  out  CNT_W  matches in the current/last run.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state = IDLE; history and fill counter cleared.
  - Config registers: pattern = 0, len = 0, overlap = 0, target = 0.
  - All outputs 0; match_count = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - cfg_we latches config.
  - start with latched len in 1..MAX_LEN → RUN next cycle; match_count and history cleared on entry.
  - start with an illegal len → stays IDLE; err pulses 1 cycle later.
  - cfg_we and start in the same cycle: config is latched first, then start uses the NEW values.
- RUN:
  - busy = 1.
  - Each in_valid beat shifts `in` into the history; fill = min(fill+1, MAX_LEN).
  - match = in_valid & (fill >= len-1) & ({history, in}[len-1:0] == pattern[len-1:0]).
  - match is combinational, in the same cycle as the final bit. No latency.
  - On a match: match_count increments on the next edge and saturates at all-ones.
    - overlap = 0: fill resets to 0 (history contents ignored).
    - overlap = 1: fill is kept.
  - If target != 0 and the incremented count == target → DONE.
  - in_valid = 0 beats change nothing and produce no match.
  - cfg_we is ignored in RUN.
- abort in RUN: → IDLE next edge with no done pulse; match_count holds; a match in the abort cycle still counts.
- abort outside RUN: ignored.
- abort and the target-reaching match in the same cycle: abort wins; the count is updated, no done.
- DONE: done = 1 for exactly one cycle, busy = 0, then IDLE. start in DONE is ignored.
- Reset in any state: forces IDLE on that edge; config is cleared.
- start while busy: ignored.

Optional Feature:
- Macro MSEQ_TIMEOUT_EN.
- Defined:
  - A counter clears on RUN entry and on every match, and increments on every other RUN cycle.
  - When it reaches TIMEOUT_CYC → DONE with timeout = 1 coincident with done.
  - A match in the expiry cycle takes precedence: the counter clears and no timeout occurs.
- Undefined: no counter; timeout tied to 0; a run ends only by target or abort.

Decomposition:
- Package mseq_pkg: state enum (IDLE/RUN/DONE), LEN_W = $clog2(MAX_LEN+1), and the default parameter constants.
- One sub-module, mseq_matcher:
  - Contents: history shift register, fill counter, and combinational compare.
  - Inputs: clear, shift, overlap.
  - Output: match.
- The controller owns the FSM, config registers, counter and timeout logic.

Test Plan:
- Config 1101, len 4, overlap 0, target 2; stream 1101101 1101 → match only on the bit-4 and bit-11 beats; count = 2; done on the cycle after the bit-11 beat.
- Same stream with overlap 1, target 0 → matches at bits 4, 7 and 11; count = 3; no done; abort → IDLE with count held at 3.
- Start with len 0, and again with len MAX_LEN+1 → err pulse, busy stays 0, count unchanged.
- Stream 1101 with in_valid toggling 1,0,1,0 → match only on the 4th valid beat; invalid beats produce no match.
- Reset driven low mid-run after 3 bits, then a new config 11 and start → no stale match; first match on the 2nd valid 1.
- With MSEQ_TIMEOUT_EN, TIMEOUT_CYC = 10, all-zero input → done and timeout pulse together 10 cycles after RUN entry; count = 0.
